// File: rtl/rename_map.sv
// Four-wide register rename stage: maps sources through the speculative map table with
// intra-group bypass, allocates packed destinations from free_list candidates, and registers the result.
module rename_map #(
  parameter int WIDTH  = 4,
  parameter int ARCH_W = 5,
  parameter int PREG_W = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [2:0]                i_count,
  input  logic [3:0]                i_rd_we,
  input  logic [ARCH_W-1:0]         i_rd0,
  input  logic [ARCH_W-1:0]         i_rd1,
  input  logic [ARCH_W-1:0]         i_rd2,
  input  logic [ARCH_W-1:0]         i_rd3,
  input  logic [ARCH_W-1:0]         i_rs1_0,
  input  logic [ARCH_W-1:0]         i_rs1_1,
  input  logic [ARCH_W-1:0]         i_rs1_2,
  input  logic [ARCH_W-1:0]         i_rs1_3,
  input  logic [ARCH_W-1:0]         i_rs2_0,
  input  logic [ARCH_W-1:0]         i_rs2_1,
  input  logic [ARCH_W-1:0]         i_rs2_2,
  input  logic [ARCH_W-1:0]         i_rs2_3,
  input  logic [PREG_W-1:0]         i_free_p0,
  input  logic [PREG_W-1:0]         i_free_p1,
  input  logic [PREG_W-1:0]         i_free_p2,
  input  logic [PREG_W-1:0]         i_free_p3,
  input  logic [5:0]                i_avail_count,
  output logic [2:0]                o_alloc_count,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [2:0]                o_count,
  output logic [PREG_W-1:0]         o_prd0,
  output logic [PREG_W-1:0]         o_prd1,
  output logic [PREG_W-1:0]         o_prd2,
  output logic [PREG_W-1:0]         o_prd3,
  output logic [PREG_W-1:0]         o_old_prd0,
  output logic [PREG_W-1:0]         o_old_prd1,
  output logic [PREG_W-1:0]         o_old_prd2,
  output logic [PREG_W-1:0]         o_old_prd3,
  output logic [PREG_W-1:0]         o_prs1_0,
  output logic [PREG_W-1:0]         o_prs1_1,
  output logic [PREG_W-1:0]         o_prs1_2,
  output logic [PREG_W-1:0]         o_prs1_3,
  output logic [PREG_W-1:0]         o_prs2_0,
  output logic [PREG_W-1:0]         o_prs2_1,
  output logic [PREG_W-1:0]         o_prs2_2,
  output logic [PREG_W-1:0]         o_prs2_3,
  output logic [3:0]                o_rd_we,
  input  logic                      i_flush,
  input  logic [32*PREG_W-1:0]      i_cmt_map
);

  localparam int NREG  = 1 << ARCH_W;
  localparam int BUS_W = 7 + 16 * PREG_W;

  logic [PREG_W-1:0] map_r     [NREG];
  logic [PREG_W-1:0] map_n_s   [NREG];
  logic [ARCH_W-1:0] rd_s      [4];
  logic [ARCH_W-1:0] rs1_s     [4];
  logic [ARCH_W-1:0] rs2_s     [4];
  logic [PREG_W-1:0] free_s    [4];
  logic [PREG_W-1:0] prd_s     [4];
  logic [PREG_W-1:0] old_s     [4];
  logic [PREG_W-1:0] prs1_s    [4];
  logic [PREG_W-1:0] prs2_s    [4];
  logic [3:0]        eff_we_s;
  logic [2:0]        need_s;
  logic              ready_s;
  logic              fire_s;

  logic              o_valid_r;
  logic [2:0]        o_count_r;
  logic [3:0]        o_rd_we_r;
  logic [PREG_W-1:0] prd_r     [4];
  logic [PREG_W-1:0] old_r     [4];
  logic [PREG_W-1:0] prs1_r    [4];
  logic [PREG_W-1:0] prs2_r    [4];
  logic [BUS_W-1:0]  out_bus_s;

  // Gather the flat slot ports into indexable arrays.
  always_comb begin
    rd_s[0]   = i_rd0;     rd_s[1]   = i_rd1;     rd_s[2]   = i_rd2;     rd_s[3]   = i_rd3;
    rs1_s[0]  = i_rs1_0;   rs1_s[1]  = i_rs1_1;   rs1_s[2]  = i_rs1_2;   rs1_s[3]  = i_rs1_3;
    rs2_s[0]  = i_rs2_0;   rs2_s[1]  = i_rs2_1;   rs2_s[2]  = i_rs2_2;   rs2_s[3]  = i_rs2_3;
    free_s[0] = i_free_p0; free_s[1] = i_free_p1; free_s[2] = i_free_p2; free_s[3] = i_free_p3;
  end

  // Packed allocation, bypass from lower slots (highest wins), and next-map computation.
  always_comb begin
    need_s   = 3'd0;
    map_n_s  = map_r;
    eff_we_s = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      eff_we_s[s] = i_rd_we[s] && (3'(s) < i_count) && (rd_s[s] != '0);
      prs1_s[s]   = map_r[rs1_s[s]];
      prs2_s[s]   = map_r[rs2_s[s]];
      old_s[s]    = map_r[rd_s[s]];
      for (int t = 0; t < s; t++) begin
        prs1_s[s] = (eff_we_s[t] && (rd_s[t] == rs1_s[s])) ? prd_s[t] : prs1_s[s];
        prs2_s[s] = (eff_we_s[t] && (rd_s[t] == rs2_s[s])) ? prd_s[t] : prs2_s[s];
        old_s[s]  = (eff_we_s[t] && (rd_s[t] == rd_s[s]))  ? prd_s[t] : old_s[s];
      end
      prs1_s[s] = (rs1_s[s] == '0) ? '0 : prs1_s[s];
      prs2_s[s] = (rs2_s[s] == '0) ? '0 : prs2_s[s];
      prd_s[s]  = eff_we_s[s] ? free_s[need_s[1:0]] : '0;
      map_n_s[rd_s[s]] = eff_we_s[s] ? prd_s[s] : map_n_s[rd_s[s]];
      need_s    = need_s + {2'b00, eff_we_s[s]};
    end
  end

  assign ready_s       = !i_flush && (!o_valid_r || i_ready) && (i_avail_count >= {3'b000, need_s});
  assign fire_s        = i_valid && ready_s;
  assign o_ready       = ready_s;
  assign o_alloc_count = fire_s ? need_s : 3'd0;

  // Speculative map table; a flush restores the committed image with x0 pinned to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int r = 0; r < NREG; r++) map_r[r] <= PREG_W'(r);
    end else if (i_flush) begin
      for (int r = 0; r < NREG; r++) map_r[r] <= (r == 0) ? '0 : i_cmt_map[r*PREG_W +: PREG_W];
    end else if (fire_s) begin
      map_r <= map_n_s;
    end else begin
      map_r <= map_r;
    end
  end

  // Output pipeline register toward dispatch; holds while dispatch is stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid_r <= 1'b0;
      o_count_r <= 3'd0;
      o_rd_we_r <= 4'b0000;
      for (int s = 0; s < 4; s++) begin
        prd_r[s] <= '0; old_r[s] <= '0; prs1_r[s] <= '0; prs2_r[s] <= '0;
      end
    end else if (i_flush) begin
      o_valid_r <= 1'b0;
    end else if (fire_s) begin
      o_valid_r <= 1'b1;
      o_count_r <= i_count;
      o_rd_we_r <= eff_we_s;
      for (int s = 0; s < 4; s++) begin
        prd_r[s] <= prd_s[s]; old_r[s] <= old_s[s]; prs1_r[s] <= prs1_s[s]; prs2_r[s] <= prs2_s[s];
      end
    end else if (i_ready) begin
      o_valid_r <= 1'b0;
    end else begin
      o_valid_r <= o_valid_r;
    end
  end

  assign o_valid    = o_valid_r;
  assign o_count    = o_count_r;
  assign o_rd_we    = o_rd_we_r;
  assign o_prd0     = prd_r[0];  assign o_prd1     = prd_r[1];
  assign o_prd2     = prd_r[2];  assign o_prd3     = prd_r[3];
  assign o_old_prd0 = old_r[0];  assign o_old_prd1 = old_r[1];
  assign o_old_prd2 = old_r[2];  assign o_old_prd3 = old_r[3];
  assign o_prs1_0   = prs1_r[0]; assign o_prs1_1   = prs1_r[1];
  assign o_prs1_2   = prs1_r[2]; assign o_prs1_3   = prs1_r[3];
  assign o_prs2_0   = prs2_r[0]; assign o_prs2_1   = prs2_r[1];
  assign o_prs2_2   = prs2_r[2]; assign o_prs2_3   = prs2_r[3];

  // Flatten the registered group so stability can be checked as one vector.
  always_comb begin
    out_bus_s      = '0;
    out_bus_s[2:0] = o_count_r;
    out_bus_s[6:3] = o_rd_we_r;
    for (int s = 0; s < 4; s++) begin
      out_bus_s[7 + s*4*PREG_W            +: PREG_W] = prd_r[s];
      out_bus_s[7 + s*4*PREG_W + PREG_W   +: PREG_W] = old_r[s];
      out_bus_s[7 + s*4*PREG_W + 2*PREG_W +: PREG_W] = prs1_r[s];
      out_bus_s[7 + s*4*PREG_W + 3*PREG_W +: PREG_W] = prs2_r[s];
    end
  end

  rename_map_chk #(.WIDTH(WIDTH), .PREG_W(PREG_W), .BUS_W(BUS_W)) u_chk (
    .clk         (i_clk),
    .rst         (i_rst),
    .fire        (fire_s),
    .flush       (i_flush),
    .count       (i_count),
    .alloc_count (o_alloc_count),
    .avail_count (i_avail_count),
    .map0        (map_r[0]),
    .out_valid   (o_valid_r),
    .out_ready   (i_ready),
    .out_bus     (out_bus_s)
  );

endmodule

// Invariant checker for rename_map: allocation bounds, x0 mapping, and output stability.
module rename_map_chk #(
  parameter int WIDTH  = 4,
  parameter int PREG_W = 6,
  parameter int BUS_W  = 103
) (
  input logic              clk,
  input logic              rst,
  input logic              fire,
  input logic              flush,
  input logic [2:0]        count,
  input logic [2:0]        alloc_count,
  input logic [5:0]        avail_count,
  input logic [PREG_W-1:0] map0,
  input logic              out_valid,
  input logic              out_ready,
  input logic [BUS_W-1:0]  out_bus
);

  a_alloc_bound: assert property (@(posedge clk) disable iff (rst) {3'b000, alloc_count} <= avail_count);
  a_alloc_idle:  assert property (@(posedge clk) disable iff (rst) !fire |-> (alloc_count == 3'd0));
  a_map0_zero:   assert property (@(posedge clk) disable iff (rst) map0 == '0);
  a_count_legal: assert property (@(posedge clk) disable iff (rst)
                                  fire |-> ((count != 3'd0) && (count <= 3'(WIDTH))));
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
                                  (out_valid && !out_ready && !flush) |=> $stable(out_bus));

endmodule

// File: tb/tb_rename_map.sv
// Scoreboard bench for rename_map: a sequential rename model predicts each accepted group,
// which is queued at fire and compared when the registered group appears.
module tb_rename_map;

  typedef struct packed {
    logic [2:0]       cnt;
    logic [3:0]       we;
    logic [3:0][5:0]  prd;
    logic [3:0][5:0]  old;
    logic [3:0][5:0]  p1;
    logic [3:0][5:0]  p2;
  } grp_t;

  logic             clk;
  logic             i_rst, i_valid, o_ready, i_ready, i_flush, o_valid;
  logic [2:0]       i_count, o_alloc_count, o_count;
  logic [3:0]       i_rd_we, o_rd_we;
  logic [4:0]       rd_a [4];
  logic [4:0]       rs1_a [4];
  logic [4:0]       rs2_a [4];
  logic [5:0]       fr_a [4];
  logic [5:0]       i_avail_count;
  logic [5:0]       o_prd [4];
  logic [5:0]       o_old [4];
  logic [5:0]       o_p1 [4];
  logic [5:0]       o_p2 [4];
  logic [32*6-1:0]  cmt;

  grp_t exp_q[$];
  grp_t last_g, obs, rg;
  int   mmap [32];
  int   nmap [32];
  bit   ov_m, load_f, chk_f;
  int   checks, errors;
  logic       obs_ready;
  logic [2:0] obs_alloc;

  rename_map dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_count(i_count), .i_rd_we(i_rd_we),
    .i_rd0(rd_a[0]), .i_rd1(rd_a[1]), .i_rd2(rd_a[2]), .i_rd3(rd_a[3]),
    .i_rs1_0(rs1_a[0]), .i_rs1_1(rs1_a[1]), .i_rs1_2(rs1_a[2]), .i_rs1_3(rs1_a[3]),
    .i_rs2_0(rs2_a[0]), .i_rs2_1(rs2_a[1]), .i_rs2_2(rs2_a[2]), .i_rs2_3(rs2_a[3]),
    .i_free_p0(fr_a[0]), .i_free_p1(fr_a[1]), .i_free_p2(fr_a[2]), .i_free_p3(fr_a[3]),
    .i_avail_count(i_avail_count), .o_alloc_count(o_alloc_count),
    .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count),
    .o_prd0(o_prd[0]), .o_prd1(o_prd[1]), .o_prd2(o_prd[2]), .o_prd3(o_prd[3]),
    .o_old_prd0(o_old[0]), .o_old_prd1(o_old[1]), .o_old_prd2(o_old[2]), .o_old_prd3(o_old[3]),
    .o_prs1_0(o_p1[0]), .o_prs1_1(o_p1[1]), .o_prs1_2(o_p1[2]), .o_prs1_3(o_p1[3]),
    .o_prs2_0(o_p2[0]), .o_prs2_1(o_p2[1]), .o_prs2_2(o_p2[2]), .o_prs2_3(o_p2[3]),
    .o_rd_we(o_rd_we), .i_flush(i_flush), .i_cmt_map(cmt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rename the current inputs one slot at a time against the model map.
  task automatic model_group(output grp_t g, output int need);
    g = '0;
    need = 0;
    nmap = mmap;
    g.cnt = i_count;
    for (int s = 0; s < 4; s++) begin
      g.p1[s] = (rs1_a[s] == 5'd0) ? 6'd0 : 6'(nmap[rs1_a[s]]);
      g.p2[s] = (rs2_a[s] == 5'd0) ? 6'd0 : 6'(nmap[rs2_a[s]]);
      if (i_rd_we[s] && (s < int'(i_count)) && (rd_a[s] != 5'd0)) begin
        g.we[s]  = 1'b1;
        g.old[s] = 6'(nmap[rd_a[s]]);
        g.prd[s] = fr_a[need];
        nmap[rd_a[s]] = int'(fr_a[need]);
        need++;
      end
    end
  endtask

  task automatic cycle();
    grp_t g;
    int   need;
    bit   er, fire;
    #1;
    model_group(g, need);
    er   = !i_flush && (!ov_m || i_ready) && (int'(i_avail_count) >= need);
    fire = i_valid && er;
    obs_ready = o_ready;
    obs_alloc = o_alloc_count;
    checks++;
    if (o_ready !== er) begin
      errors++; $display("FAIL o_ready got %b expected %b", o_ready, er);
    end
    checks++;
    if (o_alloc_count !== (fire ? 3'(need) : 3'd0)) begin
      errors++; $display("FAIL alloc_count got %0d expected %0d", o_alloc_count, fire ? need : 0);
    end
    if (fire) exp_q.push_back(g);
    @(posedge clk);
    if (i_rst) begin
      for (int r = 0; r < 32; r++) mmap[r] = r;
      ov_m = 1'b0;
      if (fire) void'(exp_q.pop_back());
    end else if (i_flush) begin
      for (int r = 0; r < 32; r++) mmap[r] = int'(cmt[r*6 +: 6]);
      mmap[0] = 0;
      ov_m = 1'b0;
    end else if (fire) begin
      mmap = nmap;
      ov_m = 1'b1;
    end else if (i_ready) begin
      ov_m = 1'b0;
    end
    load_f = fire && !i_rst;
    chk_f  = 1'b1;
    #1;
  endtask

  // Scoreboard monitor: compare newly loaded groups against the queue, held groups against the last one.
  always @(negedge clk) begin
    if (chk_f) begin
      chk_f = 1'b0;
      checks++;
      if (o_valid !== ov_m) begin
        errors++; $display("FAIL o_valid got %b expected %b", o_valid, ov_m);
      end
      obs.cnt = o_count;
      obs.we  = o_rd_we;
      for (int i = 0; i < 4; i++) begin
        obs.prd[i] = o_prd[i]; obs.old[i] = o_old[i]; obs.p1[i] = o_p1[i]; obs.p2[i] = o_p2[i];
      end
      if (load_f && exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty got no expected group");
      end else if (load_f || ov_m) begin
        if (load_f) begin
          rg = exp_q.pop_front();
          last_g = rg;
        end else begin
          rg = last_g;
        end
        load_f = 1'b0;
        checks++;
        if ({obs.cnt, obs.we} !== {rg.cnt, rg.we}) begin
          errors++; $display("FAIL grp_cnt_we got %h expected %h", {obs.cnt, obs.we}, {rg.cnt, rg.we});
        end
        checks++;
        if (obs.prd !== rg.prd) begin
          errors++; $display("FAIL grp_prd got %h expected %h", obs.prd, rg.prd);
        end
        checks++;
        if ({obs.p1, obs.p2} !== {rg.p1, rg.p2}) begin
          errors++; $display("FAIL grp_prs got %h expected %h", {obs.p1, obs.p2}, {rg.p1, rg.p2});
        end
        for (int i = 0; i < 4; i++) begin
          if (rg.we[i]) begin
            checks++;
            if (obs.old[i] !== rg.old[i]) begin
              errors++; $display("FAIL grp_old%0d got %0d expected %0d", i, obs.old[i], rg.old[i]);
            end
          end
        end
      end
    end
  end

  task automatic set_group(input logic [2:0] cnt, input logic [3:0] we,
                           input logic [3:0][4:0] rd, input logic [3:0][4:0] rs1,
                           input logic [3:0][4:0] rs2, input logic [3:0][5:0] fr,
                           input logic [5:0] avail);
    i_valid = 1'b1; i_count = cnt; i_rd_we = we; i_avail_count = avail;
    for (int i = 0; i < 4; i++) begin
      rd_a[i] = rd[i]; rs1_a[i] = rs1[i]; rs2_a[i] = rs2[i]; fr_a[i] = fr[i];
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    set_group(3'd1, 4'b0000, '0, '0, '0, '0, 6'd32);
    i_valid = 1'b0;
    for (int r = 0; r < 32; r++) cmt[r*6 +: 6] = 6'(r);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_valid, o_count, o_rd_we, o_prd[0], o_old[3], o_p1[1], o_p2[2]} !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got valid=%b count=%0d we=%b", o_valid, o_count, o_rd_we);
    end
    i_rst = 1'b0;
    for (int r = 0; r < 32; r++) mmap[r] = r;
    ov_m = 1'b0;
    set_group(3'd4, 4'b0000, '0, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd0, 5'd29, 5'd30, 5'd31}, '0, 6'd32);
    cycle();
    checks++;
    if ({o_p1[3], o_p2[0]} !== {6'd4, 6'd31}) begin
      errors++; $display("FAIL reset_identity got %0d,%0d expected 4,31", o_p1[3], o_p2[0]);
    end
  endtask

  task automatic test_basic();
    set_group(3'd4, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd3, 5'd2, 5'd1, 5'd0}, '0,
              {6'd35, 6'd34, 6'd33, 6'd32}, 6'd32);
    cycle();
    checks++;
    if (obs_alloc !== 3'd4) begin
      errors++; $display("FAIL basic_alloc got %0d expected 4", obs_alloc);
    end
    checks++;
    if ({o_prd[3], o_prd[2], o_prd[1], o_prd[0]} !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
      errors++; $display("FAIL basic_prd got %0d %0d %0d %0d", o_prd[0], o_prd[1], o_prd[2], o_prd[3]);
    end
    checks++;
    if ({o_old[3], o_old[2], o_old[1], o_old[0], o_valid} !== {6'd4, 6'd3, 6'd2, 6'd1, 1'b1}) begin
      errors++; $display("FAIL basic_old got %0d %0d %0d %0d", o_old[0], o_old[1], o_old[2], o_old[3]);
    end
  endtask

  task automatic test_bypass();
    set_group(3'd3, 4'b0111, {5'd0, 5'd6, 5'd5, 5'd5}, {5'd0, 5'd0, 5'd5, 5'd0},
              {5'd0, 5'd5, 5'd0, 5'd0}, {6'd43, 6'd42, 6'd41, 6'd40}, 6'd32);
    cycle();
    checks++;
    if ({o_p1[1], o_old[1], o_p2[2], o_old[0]} !== {6'd40, 6'd40, 6'd41, 6'd5}) begin
      errors++; $display("FAIL bypass got prs1_1=%0d old1=%0d prs2_2=%0d old0=%0d",
                         o_p1[1], o_old[1], o_p2[2], o_old[0]);
    end
    set_group(3'd1, 4'b0000, '0, {5'd0, 5'd0, 5'd0, 5'd5}, {5'd0, 5'd0, 5'd0, 5'd6}, '0, 6'd32);
    cycle();
    checks++;
    if ({o_p1[0], o_p2[0]} !== {6'd41, 6'd42}) begin
      errors++; $display("FAIL bypass_next got %0d,%0d expected 41,42", o_p1[0], o_p2[0]);
    end
  endtask

  task automatic test_sparse();
    set_group(3'd4, 4'b1010, {5'd9, 5'd0, 5'd7, 5'd0}, {5'd7, 5'd0, 5'd0, 5'd0}, '0,
              {6'd53, 6'd52, 6'd51, 6'd50}, 6'd32);
    cycle();
    checks++;
    if ({obs_alloc, o_prd[3], o_prd[2], o_prd[1], o_prd[0], o_p1[3]} !==
        {3'd2, 6'd51, 6'd0, 6'd50, 6'd0, 6'd50}) begin
      errors++; $display("FAIL sparse got alloc=%0d prd=%0d %0d %0d %0d", obs_alloc,
                         o_prd[0], o_prd[1], o_prd[2], o_prd[3]);
    end
  endtask

  task automatic test_x0();
    set_group(3'd2, 4'b0001, '0, '0, '0, {6'd57, 6'd56, 6'd55, 6'd54}, 6'd32);
    cycle();
    checks++;
    if ({obs_alloc, o_rd_we, o_prd[0], o_p1[0], o_p2[1], o_valid} !== {3'd0, 4'b0000, 6'd0, 6'd0, 6'd0, 1'b1}) begin
      errors++; $display("FAIL x0_dest got alloc=%0d we=%b prd0=%0d", obs_alloc, o_rd_we, o_prd[0]);
    end
  endtask

  task automatic test_stall();
    set_group(3'd3, 4'b0111, {5'd0, 5'd12, 5'd11, 5'd10}, {5'd0, 5'd10, 5'd0, 5'd0}, '0,
              {6'd0, 6'd47, 6'd46, 6'd45}, 6'd2);
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if ({obs_ready, obs_alloc} !== 4'b0000) begin
        errors++; $display("FAIL stall_%0d got ready=%b alloc=%0d", k, obs_ready, obs_alloc);
      end
    end
    i_avail_count = 6'd3;
    cycle();
    checks++;
    if ({obs_ready, obs_alloc, o_prd[0], o_p1[2]} !== {1'b1, 3'd3, 6'd45, 6'd45}) begin
      errors++; $display("FAIL stall_release got ready=%b alloc=%0d prd0=%0d", obs_ready, obs_alloc, o_prd[0]);
    end
  endtask

  task automatic test_backpressure();
    set_group(3'd1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd13}, '0, '0, {6'd0, 6'd0, 6'd0, 6'd60}, 6'd32);
    cycle();
    i_ready = 1'b0;
    set_group(3'd1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd14}, '0, '0, {6'd0, 6'd0, 6'd0, 6'd61}, 6'd32);
    repeat (2) begin
      cycle();
      checks++;
      if ({obs_ready, o_valid, o_prd[0]} !== {1'b0, 1'b1, 6'd60}) begin
        errors++; $display("FAIL bp_hold got ready=%b valid=%b prd0=%0d", obs_ready, o_valid, o_prd[0]);
      end
    end
    i_ready = 1'b1;
    cycle();
    checks++;
    if ({obs_ready, o_prd[0]} !== {1'b1, 6'd61}) begin
      errors++; $display("FAIL bp_release got ready=%b prd0=%0d", obs_ready, o_prd[0]);
    end
  endtask

  task automatic test_flush();
    set_group(3'd1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1}, '0, '0, {6'd0, 6'd0, 6'd0, 6'd32}, 6'd32);
    cycle();
    cmt[0 +: 6] = 6'd7;
    cmt[2*6 +: 6] = 6'd20;
    i_flush = 1'b1;
    set_group(3'd1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1}, '0, '0, {6'd0, 6'd0, 6'd0, 6'd33}, 6'd32);
    cycle();
    checks++;
    if ({obs_ready, obs_alloc, o_valid} !== 5'b00000) begin
      errors++; $display("FAIL flush got ready=%b alloc=%0d valid=%b", obs_ready, obs_alloc, o_valid);
    end
    i_flush = 1'b0;
    set_group(3'd1, 4'b0000, '0, {5'd0, 5'd0, 5'd0, 5'd1}, {5'd0, 5'd0, 5'd0, 5'd2}, '0, 6'd32);
    cycle();
    checks++;
    if ({o_p1[0], o_p2[0]} !== {6'd1, 6'd20}) begin
      errors++; $display("FAIL flush_restore got %0d,%0d expected 1,20", o_p1[0], o_p2[0]);
    end
    set_group(3'd1, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, '0, '0, {6'd0, 6'd0, 6'd0, 6'd44}, 6'd32);
    cycle();
    cmt[3*6 +: 6] = 6'd45;
    i_rst = 1'b1; i_flush = 1'b1;
    cycle();
    checks++;
    if ({o_valid, o_count, o_prd[0]} !== 10'd0) begin
      errors++; $display("FAIL rst_flush_out got valid=%b count=%0d prd0=%0d", o_valid, o_count, o_prd[0]);
    end
    i_rst = 1'b0; i_flush = 1'b0;
    set_group(3'd1, 4'b0000, '0, {5'd0, 5'd0, 5'd0, 5'd3}, {5'd0, 5'd0, 5'd0, 5'd2}, '0, 6'd32);
    cycle();
    checks++;
    if ({o_p1[0], o_p2[0]} !== {6'd3, 6'd2}) begin
      errors++; $display("FAIL rst_flush_map got %0d,%0d expected 3,2", o_p1[0], o_p2[0]);
    end
  endtask

  initial begin
    checks = 0; errors = 0; ov_m = 1'b0; load_f = 1'b0; chk_f = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_sparse();
    test_x0();
    test_stall();
    test_backpressure();
    test_flush();
    i_valid = 1'b0;
    repeat (2) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_map.md
Name: rename_map

Overview:
- 4-wide register rename stage that sits directly upstream of free_list.
- Each cycle it accepts a decoded group of up to 4 instructions and maps source architectural registers to physical registers.
- It allocates new physical destinations from the free_list's head candidates, drives the free_list request count, and records the displaced mapping so retirement can later return it.
- Output is a registered pipeline stage with a valid/ready handshake toward dispatch.

Parameters:
- WIDTH, 4, instructions per group. Slot ports are fixed at 4; WIDTH sets count-field checks only.
- ARCH_W, 5, architectural register index width (32 regs).
- PREG_W, 6, physical register index width (64 pregs); matches free_list.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  decoded group valid
- o_ready  out  1  group accepted this cycle when i_valid is also high
- i_count  in  3  slots valid in group (1..4); slots 0..i_count-1 are live
- i_rd_we  in  4  per-slot destination write enable
- i_rd0..i_rd3  in  ARCH_W each  destination architectural regs
- i_rs1_0..i_rs1_3, i_rs2_0..i_rs2_3  in  ARCH_W each  source architectural regs
- i_free_p0..i_free_p3  in  PREG_W each  free_list head candidates, valid in the current cycle
- i_avail_count  in  6  free_list available count
- o_alloc_count  out  3  pregs consumed this cycle; drives free_list i_req_count
- o_valid  out  1  renamed group valid
- i_ready  in  1  dispatch accepts the renamed group
- o_count  out  3  registered copy of i_count
- o_prd0..3, o_old_prd0..3, o_prs1_0..3, o_prs2_0..3  out  PREG_W each  renamed operands
- o_rd_we  out  4  effective write enable (rd==0 cleared)
- i_flush  in  1  squash and restore the map
- i_cmt_map  in  32*PREG_W  committed map, entry r at bits [r*PREG_W +: PREG_W]

Behaviour:
- Map table: 32 x PREG_W registers.
  - Reset: entry r = r.
  - Entry 0 is always 0 and is never written.
- Effective write for slot s: eff_we[s] = i_rd_we[s] && s < i_count && rd_s != 0.
- need = popcount(eff_we), range 0..4.
- o_ready = !i_flush && (!o_valid || i_ready) && (i_avail_count >= need).
- fire = i_valid && o_ready.
- Allocation is packed: the k-th slot (in slot order) with eff_we takes i_free_p[k].
  - o_alloc_count = fire ? need : 0. This is combinational, the same cycle as fire.
  - free_list removes the consumed pregs at that clock edge.
- Intra-group bypass, for slot s and source rs:
  - If a lower slot t<s has eff_we and rd_t == rs, use the prd of the highest such t.
  - Otherwise use map[rs].
  - rs == 0 always yields 0.
- o_old_prd[s]: the prd of the highest lower slot writing the same rd, else map[rd_s]. Only meaningful when eff_we[s].
- o_prd[s] for a slot without eff_we is 0.
- Map update on fire: for each rd, the highest slot writing it wins. Visible to the next group with no bubble.
- Output register:
  - On fire, load all o_* fields and set o_valid = 1.
  - Else if i_ready, clear o_valid.
  - Else hold all outputs.
- Zero-destination groups (need == 0) still fire, with o_alloc_count = 0.
- Flush (i_flush), synchronous:
  - o_valid = 0, map = i_cmt_map (entry 0 forced 0), o_ready = 0, o_alloc_count = 0.
  - The in-flight input group is dropped.
  - Flush has priority over fire and over reset-free operation.
- Reset: map identity, o_valid = 0, all o_* data = 0, o_count = 0, o_rd_we = 0.
  - Reset dominates flush.
  - Reset mid-stream discards the held output group.
- Stall: if i_avail_count < need, nothing is allocated and the map is unchanged; the group retries every cycle.
- Backpressure: o_valid && !i_ready holds o_* stable and forces o_ready = 0.
- Invariants to assert:
  - o_alloc_count <= i_avail_count.
  - o_alloc_count == 0 when !fire.
  - Map entry 0 == 0.
  - Outputs stable while o_valid && !i_ready.

Test Plan:
- Reset, then group count=4, rd={1,2,3,4}, we=4'b1111, free_p={32,33,34,35}, avail=32 -> o_alloc_count=4 same cycle; next cycle o_prd={32,33,34,35}, o_old_prd={1,2,3,4}, o_valid=1.
- Bypass: count=3, slot0 rd=5, slot1 rs1=5 rd=5, slot2 rs2=5; free_p={40,41,..} -> o_prs1_1=40, o_old_prd1=40, o_prs2_2=41; next group rs1=5 reads 41.
- Sparse we=4'b1010, rd1=7, rd3=9, free_p={50,51,52,53} -> o_prd1=50, o_prd3=51, o_prd0=o_prd2=0, o_alloc_count=2.
- x0 dest: rd0=0, we0=1 -> eff_we0=0, alloc 0, map[0] stays 0, o_prs of x0 = 0.
- avail=2 with need=3 -> o_ready=0, o_alloc_count=0 for 3 cycles; avail rises to 3 -> fires that cycle. Separately, i_ready=0 with o_valid=1 -> outputs held, o_ready=0.
- i_flush asserted together with i_valid after renaming r1->32 -> o_alloc_count=0, o_valid=0 next cycle, map[1]=i_cmt_map entry 1 (e.g. 1); rst asserted together with flush -> identity map.
